// File: rtl/serial_rx_if.sv
// Serial receiver port bundle: the serial line in, the parallel word and status out.
// The receiver connects through master, and a consumer or stimulus source connects through slave.
interface serial_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 bit_in_rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (
    input  bit_in_rx,
    output data_out,
    output data_valid,
    output frame_err,
    output rx_busy
  );

  modport slave (
    output bit_in_rx,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  rx_busy
  );
endinterface

// File: rtl/serial_rx.sv
// UART-style serial receiver for the ADC link.
// It oversamples the line on baud_clk and decides each bit at its midpoint.
// A frame is one start bit (0), DATA_BITS data bits sent MSB first, and one stop bit (1).
module serial_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic          baud_clk,
  input  logic          reset,
  serial_rx_if.master   rx
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;

  // Tick values at which a bit is sampled: the middle of the start bit,
  // and one full bit period later for each data bit and for the stop bit.
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE/2 - 1);
  localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [1:0]           sync_reg;
  logic                 rx_s;
  logic [TICK_W-1:0]    tick_reg, tick_next;
  logic [BIT_W-1:0]     bit_reg, bit_next;
  logic [DATA_BITS-1:0] shreg_reg, shreg_next;
  logic [DATA_BITS-1:0] data_out_reg;
  logic                 valid_reg, valid_next;
  logic                 err_reg, err_next;
  logic                 load_word;

  // Two-flop synchroniser for the asynchronous line. It resets to idle-high so that reset cannot look like a start bit.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx.bit_in_rx};
    end
  end

  assign rx_s = sync_reg[1];

  // State register.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode. Every decision uses only the synchronised line rx_s.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        // A line that is high again at mid start bit is a glitch, not a frame.
        if (tick_reg == TICK_HALF) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick_reg == TICK_FULL && bit_reg == BIT_LAST) state_next = STOP;
      end
      STOP: begin
        // Return at mid stop bit so that a start bit right after it is not missed.
        if (tick_reg == TICK_FULL) state_next = rx_s ? IDLE : BRK;
      end
      BRK: begin
        // A line held low (break) must go high before a new start is armed.
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and pulse decode: the counters, the shift register, and the values of the registered pulses for the next cycle.
  always_comb begin
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    shreg_next = shreg_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    load_word  = 1'b0;
    case (state_reg)
      IDLE: begin
        tick_next = '0;
        bit_next  = '0;
      end
      START: begin
        if (tick_reg == TICK_HALF) begin
          tick_next = '0;
          bit_next  = '0;
        end else begin
          tick_next = tick_reg + TICK_W'(1);
        end
      end
      DATA: begin
        if (tick_reg == TICK_FULL) begin
          shreg_next = {shreg_reg[DATA_BITS-2:0], rx_s};
          tick_next  = '0;
          if (bit_reg != BIT_LAST) bit_next = bit_reg + BIT_W'(1);
        end else begin
          tick_next = tick_reg + TICK_W'(1);
        end
      end
      STOP: begin
        if (tick_reg == TICK_FULL) begin
          tick_next = '0;
          if (rx_s) begin
            valid_next = 1'b1;
            load_word  = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end else begin
          tick_next = tick_reg + TICK_W'(1);
        end
      end
      BRK: begin
        tick_next = '0;
      end
      default: begin
        tick_next = '0;
        bit_next  = '0;
      end
    endcase
  end

  // Datapath registers. data_out changes only when a good word is loaded or on reset.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      tick_reg     <= '0;
      bit_reg      <= '0;
      shreg_reg    <= '0;
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      shreg_reg <= shreg_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
      if (load_word) data_out_reg <= shreg_reg;
    end
  end

  assign rx.data_out   = data_out_reg;
  assign rx.data_valid = valid_reg;
  assign rx.frame_err  = err_reg;
  assign rx.rx_busy    = (state_reg != IDLE);

endmodule
